// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle MIPS controller and its datapath.
//   Op, Zero, MemReady    : datapath -> controller
//   PCWrite .. IllegalOp  : controller -> datapath (mux selects, enables, ALU op)
//   RetireCount           : retired-instruction counter, CNT_W bits
//   DbgState              : current controller state code, for observation only
// Handshake: a memory state (FETCH, MEMRD, MEMWR) asserts its request
// (MemRead or MemWrite) and holds it every cycle until the memory answers
// with MemReady=1 in the same cycle; the transfer completes on that edge.
// The controller never withdraws a request before MemReady.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic [3:0]       ALUOp;
  logic             IllegalOp;
  logic [CNT_W-1:0] RetireCount;
  logic [3:0]       DbgState;

  modport master (
    input  Op, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, IllegalOp, RetireCount, DbgState
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, IllegalOp, RetireCount, DbgState
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for a shared-ALU / shared-memory multicycle MIPS datapath.
// Sequences R-type, LW, SW, BEQ, ADDI and ADDIU one step per clock, counts
// retired instructions and flags unsupported opcodes in DECODE.
// Ports:
//   Clk    : clock, rising edge
//   Reset  : synchronous, active-high
//   bus    : multicycle_control_if.master (opcode, Zero, MemReady in;
//            all datapath controls, RetireCount and DbgState out)
// Parameters:
//   CNT_W   : RetireCount width (must match the interface's CNT_W)
//   WAIT_EN : 1 = memory states wait for MemReady, 0 = MemReady treated as 1
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] retire_cnt;
  logic             mem_rdy;
  logic             retire;

  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [3:0]       alu_op;
  logic             illegal_op;

  assign mem_rdy = WAIT_EN ? bus.MemReady : 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_FETCH;
      op_q       <= 6'b000000;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      // IEXEC picks ADDI vs ADDIU from this copy, so Op may move on after DECODE.
      if (state == S_DECODE) op_q <= bus.Op;
      // Natural binary wrap from all ones back to zero.
      if (retire) retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt     = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 4'b0000;
    illegal_op    = 1'b0;
    retire        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 are committed only on the edge the fetch completes.
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        state_nxt = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW:      state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_REXEC;
          OP_BEQ:            state_nxt = S_BEQ;
          OP_ADDI, OP_ADDIU: state_nxt = S_IEXEC;
          default: begin
            // Also catches X/Z opcodes in simulation.
            state_nxt  = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.Op == OP_LW)      state_nxt = S_MEMRD;
        else if (bus.Op == OP_SW) state_nxt = S_MEMWR;
        else                      state_nxt = S_FETCH;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_rdy;
        state_nxt = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0010;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 4'b0001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ADDIU) ? 4'b0101 : 4'b0100;
        state_nxt = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Write enables and memory requests are squashed during reset so the
  // datapath sees no side effects from whatever state is being abandoned.
  assign bus.PCWrite     = pc_write      & ~Reset;
  assign bus.PCWriteCond = pc_write_cond & ~Reset;
  assign bus.MemRead     = mem_read      & ~Reset;
  assign bus.MemWrite    = mem_write     & ~Reset;
  assign bus.IRWrite     = ir_write      & ~Reset;
  assign bus.RegWrite    = reg_write     & ~Reset;
  assign bus.IorD        = iord;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = alu_op;
  assign bus.IllegalOp   = illegal_op;
  assign bus.RetireCount = retire_cnt;
  assign bus.DbgState    = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) ia ();
  multicycle_control_if #(.CNT_W(4))  ib ();

  multicycle_control #(.CNT_W(32), .WAIT_EN(1'b1)) u_dut_a (
    .Clk(clk), .Reset(rst_a), .bus(ia.master)
  );
  multicycle_control #(.CNT_W(4), .WAIT_EN(1'b0)) u_dut_b (
    .Clk(clk), .Reset(rst_b), .bus(ib.master)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  st;
    logic [18:0] outs;
    logic [31:0] ret;
  } vec_t;
  vec_t tbl[$];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mk(input bit pcw, input bit pcwc, input bit iord,
                                     input bit mr, input bit mw, input bit irw,
                                     input bit m2r, input bit rd, input bit rw,
                                     input bit asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [3:0] aluop,
                                     input bit ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aluop, ill};
  endfunction

  function automatic logic [18:0] outs_a();
    return {ia.PCWrite, ia.PCWriteCond, ia.IorD, ia.MemRead, ia.MemWrite, ia.IRWrite,
            ia.MemtoReg, ia.RegDst, ia.RegWrite, ia.ALUSrcA, ia.ALUSrcB, ia.PCSource,
            ia.ALUOp, ia.IllegalOp};
  endfunction

  task automatic add(input logic [5:0] op, input logic [3:0] st,
                     input logic [18:0] outs, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.st = st; v.outs = outs; v.ret = ret;
    tbl.push_back(v);
  endtask

  // Reference model: each instruction is a list of steps; a memory step lasts
  // until MemReady is seen high, every other step lasts one cycle.
  function automatic void model(input logic [5:0] op, input logic [63:0] mrv,
                                output int cyc, output int rw, output int mw,
                                output int mrd, output int ill, output int ret);
    int i;
    i = 0; rw = 0; mw = 0; mrd = 0; ill = 0; ret = 0;
    do begin mrd++; i++; end while (!mrv[i-1] && i < 64);   // instruction fetch
    i++;                                                     // decode
    case (op)
      OP_LW: begin
        i++;
        do begin mrd++; i++; end while (!mrv[i-1] && i < 64);
        i++; rw = 1; ret = 1;
      end
      OP_SW: begin
        i++;
        do begin mw++; i++; end while (!mrv[i-1] && i < 64);
        ret = 1;
      end
      OP_R, OP_ADDI, OP_ADDIU: begin i += 2; rw = 1; ret = 1; end
      OP_BEQ: begin i++; ret = 1; end
      default: ill = 1;
    endcase
    cyc = i;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [18:0] v_fetch, v_dec, v_dec_ill, v_madr, v_mrd, v_mwb, v_mwr;
    logic [18:0] v_rex, v_rwb, v_beq, v_iex_addi, v_iex_addiu, v_iwb;
    logic [31:0] exp_retire;

    v_fetch     = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,4'b0000,0);
    v_dec       = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0000,0);
    v_dec_ill   = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0000,1);
    v_madr      = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0000,0);
    v_mrd       = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0);
    v_mwb       = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,0);
    v_mwr       = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'b0000,0);
    v_rex       = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0010,0);
    v_rwb       = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0000,0);
    v_beq       = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0001,0);
    v_iex_addi  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0100,0);
    v_iex_addiu = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0101,0);
    v_iwb       = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0000,0);

    // One instruction per group, MemReady held high; ret is RetireCount in that cycle.
    add(OP_R, 0, v_fetch, 0); add(OP_R, 1, v_dec, 0); add(OP_R, 6, v_rex, 0); add(OP_R, 7, v_rwb, 0);
    add(OP_LW, 0, v_fetch, 1); add(OP_LW, 1, v_dec, 1); add(OP_LW, 2, v_madr, 1);
    add(OP_LW, 3, v_mrd, 1); add(OP_LW, 4, v_mwb, 1);
    add(OP_SW, 0, v_fetch, 2); add(OP_SW, 1, v_dec, 2); add(OP_SW, 2, v_madr, 2); add(OP_SW, 5, v_mwr, 2);
    add(OP_BEQ, 0, v_fetch, 3); add(OP_BEQ, 1, v_dec, 3); add(OP_BEQ, 8, v_beq, 3);
    add(OP_ADDI, 0, v_fetch, 4); add(OP_ADDI, 1, v_dec, 4); add(OP_ADDI, 9, v_iex_addi, 4); add(OP_ADDI, 10, v_iwb, 4);
    add(OP_ADDIU, 0, v_fetch, 5); add(OP_ADDIU, 1, v_dec, 5); add(OP_ADDIU, 9, v_iex_addiu, 5); add(OP_ADDIU, 10, v_iwb, 5);
    add(OP_BAD, 0, v_fetch, 6); add(OP_BAD, 1, v_dec_ill, 6);

    ia.Op = OP_R; ia.Zero = 1'b0; ia.MemReady = 1'b1;
    ib.Op = OP_ADDIU; ib.Zero = 1'b0; ib.MemReady = 1'b0;

    // ---- reset: two cycles, requests forced low while Reset is high ----
    rst_a = 1'b1;
    tick(); tick();
    #1;
    chk("reset_state", {28'd0, ia.DbgState}, 32'd0);
    chk("reset_retire", ia.RetireCount, 32'd0);
    chk("reset_memread", {31'd0, ia.MemRead}, 32'd0);
    chk("reset_irwrite", {31'd0, ia.IRWrite}, 32'd0);
    chk("reset_pcwrite", {31'd0, ia.PCWrite}, 32'd0);
    rst_a = 1'b0;
    #1;
    chk("first_fetch_req", {31'd0, ia.MemRead}, 32'd1);

    // ---- table-driven sequences ----
    foreach (tbl[k]) begin
      ia.Op = tbl[k].op; ia.MemReady = 1'b1; ia.Zero = 1'b1;
      #1;
      chk($sformatf("tbl%0d_state", k), {28'd0, ia.DbgState}, {28'd0, tbl[k].st});
      chk($sformatf("tbl%0d_outs", k), {13'd0, outs_a()}, {13'd0, tbl[k].outs});
      chk($sformatf("tbl%0d_retire", k), ia.RetireCount, tbl[k].ret);
      tick();
    end
    chk("tbl_end_retire", ia.RetireCount, 32'd6);
    chk("tbl_end_state", {28'd0, ia.DbgState}, 32'd0);

    // ---- FETCH wait: nothing committed until MemReady ----
    ia.Op = OP_LW; ia.MemReady = 1'b0;
    #1;
    chk("fwait_irwrite", {31'd0, ia.IRWrite}, 32'd0);
    chk("fwait_pcwrite", {31'd0, ia.PCWrite}, 32'd0);
    chk("fwait_memread", {31'd0, ia.MemRead}, 32'd1);
    tick();
    chk("fwait_state", {28'd0, ia.DbgState}, 32'd0);

    // ---- LW with 3 wait cycles in MEMRD: 8 cycles total ----
    for (int c = 0; c < 8; c++) begin
      ia.Op = OP_LW;
      ia.MemReady = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      #1;
      if (c >= 3 && c <= 5) begin
        chk($sformatf("lwwait%0d_state", c), {28'd0, ia.DbgState}, 32'd3);
        chk($sformatf("lwwait%0d_rd_iord", c), {30'd0, ia.MemRead, ia.IorD}, 32'd3);
      end
      if (c == 7) begin
        chk("lw_memwb_state", {28'd0, ia.DbgState}, 32'd4);
        chk("lw_memwb_m2r", {31'd0, ia.MemtoReg}, 32'd1);
      end
      tick();
    end
    chk("lw_end_state", {28'd0, ia.DbgState}, 32'd0);
    chk("lw_end_retire", ia.RetireCount, 32'd7);

    // ---- reset in the middle of a MEMWR wait ----
    for (int c = 0; c < 3; c++) begin
      ia.Op = OP_SW; ia.MemReady = 1'b1;
      tick();
    end
    ia.MemReady = 1'b0;
    #1;
    chk("swwait_state", {28'd0, ia.DbgState}, 32'd5);
    chk("swwait_memwrite", {31'd0, ia.MemWrite}, 32'd1);
    tick();
    rst_a = 1'b1;
    #1;
    chk("swrst_memwrite", {31'd0, ia.MemWrite}, 32'd0);
    tick();
    chk("swrst_state", {28'd0, ia.DbgState}, 32'd0);
    chk("swrst_retire", ia.RetireCount, 32'd0);
    rst_a = 1'b0;
    ia.MemReady = 1'b1;

    // ---- randomized instructions against the step-list model ----
    exp_retire = 0;
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  op;
      logic [63:0] mrv;
      int e_cyc, e_rw, e_mw, e_mrd, e_ill, e_ret;
      int a_cyc, a_rw, a_mw, a_mrd, a_ill;
      bit left, done;
      case ($urandom_range(0, 6))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_ADDIU;
        default: begin
          op = 6'($urandom);
          while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                 op == OP_ADDI || op == OP_ADDIU) op = 6'($urandom);
        end
      endcase
      mrv = {$urandom, $urandom} | {$urandom, $urandom};
      model(op, mrv, e_cyc, e_rw, e_mw, e_mrd, e_ill, e_ret);
      exp_q.push_back(32'(e_cyc));
      exp_retire = exp_retire + 32'(e_ret);

      a_cyc = 0; a_rw = 0; a_mw = 0; a_mrd = 0; a_ill = 0;
      left = 1'b0; done = 1'b0;
      while (!done && a_cyc < 64) begin
        ia.Op = op; ia.MemReady = mrv[a_cyc]; ia.Zero = 1'($urandom);
        #1;
        a_rw  += int'(ia.RegWrite);
        a_mw  += int'(ia.MemWrite);
        a_mrd += int'(ia.MemRead);
        a_ill += int'(ia.IllegalOp);
        tick();
        a_cyc++;
        if (ia.DbgState != 4'd0) left = 1'b1;
        else if (left) done = 1'b1;
      end
      chk($sformatf("rnd%0d_op%b_timeout", n, op), {31'd0, done}, 32'd1);
      chk($sformatf("rnd%0d_op%b_cycles", n, op), 32'(a_cyc), exp_q.pop_front());
      chk($sformatf("rnd%0d_op%b_regwrite", n, op), 32'(a_rw), 32'(e_rw));
      chk($sformatf("rnd%0d_op%b_memwrite", n, op), 32'(a_mw), 32'(e_mw));
      chk($sformatf("rnd%0d_op%b_memread", n, op), 32'(a_mrd), 32'(e_mrd));
      chk($sformatf("rnd%0d_op%b_illegal", n, op), 32'(a_ill), 32'(e_ill));
      chk($sformatf("rnd%0d_op%b_retire", n, op), ia.RetireCount, exp_retire);
    end

    // ---- narrow counter, MemReady ignored: 16 ADDIU wrap 15 -> 0 ----
    tick(); tick();
    rst_b = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      int cyc;
      bit left, done;
      cyc = 0; left = 1'b0; done = 1'b0;
      while (!done && cyc < 16) begin
        ib.Op = OP_ADDIU; ib.MemReady = 1'b0;
        #1;
        if (ib.DbgState == 4'd9)
          chk($sformatf("b%0d_iexec_aluop", n), {28'd0, ib.ALUOp}, 32'd5);
        tick();
        cyc++;
        if (ib.DbgState != 4'd0) left = 1'b1;
        else if (left) done = 1'b1;
      end
      chk($sformatf("b%0d_cycles", n), 32'(cyc), 32'd4);
      chk($sformatf("b%0d_retire", n), {28'd0, ib.RetireCount}, 32'(n % 16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
